// File: rtl/hex_counter_pkg.sv
// Shared constants for the hex counter/display slice: segment width,
// blank pattern and the active-low seven-segment glyph table.
package hex_counter_pkg;

  localparam int unsigned SEG_W = 7;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

  // Active-low, bit0 = a ... bit6 = g; index is the nibble value 0-F.
  localparam logic [SEG_W-1:0] SEG7_GLYPH [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  function automatic logic [SEG_W-1:0] seg7_glyph(input logic [3:0] nib);
    return SEG7_GLYPH[nib];
  endfunction

endpackage

// File: rtl/hex_counter_nd_seg7_decode.sv
// Single-digit nibble to active-low seven-segment decoder with a blank override.
module seg7_decode
  import hex_counter_pkg::*;
(
  input  logic [3:0]       i_nib,
  input  logic             i_blank,
  output logic [SEG_W-1:0] o_seg
);

  assign o_seg = i_blank ? SEG_BLANK : seg7_glyph(i_nib);

endmodule

// File: rtl/hex_counter_nd.sv
// N-digit modulo up/down counter with parallel load, terminal count and
// seven-segment outputs. Define HEX_COUNTER_BLANK_EN for leading-zero blanking.
module hex_counter_nd
  import hex_counter_pkg::*;
#(
  parameter int unsigned     DIGITS  = 2,
  parameter longint unsigned MODULUS = 64'd1 << (4 * DIGITS)
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic                    en,
  input  logic                    up,
  input  logic                    load,
  input  logic [4*DIGITS-1:0]     load_val,
  output logic [4*DIGITS-1:0]     count,
  output logic                    tc,
  output logic [SEG_W*DIGITS-1:0] hex
);

  localparam int unsigned W = 4 * DIGITS;
  localparam logic [W-1:0] MAX_VAL = W'(MODULUS - 64'd1);

  logic [W-1:0]      r_count;
  logic [W-1:0]      w_load_clamped;
  logic              w_at_max;
  logic              w_at_zero;
  logic [DIGITS-1:0] w_blank;

  // Compare in 64 bits so MODULUS = 2**W never truncates to zero.
  assign w_load_clamped = (64'(load_val) < MODULUS) ? load_val : MAX_VAL;
  assign w_at_max       = (r_count == MAX_VAL);
  assign w_at_zero      = (r_count == '0);

  always_ff @(posedge clk) begin
    if (clr) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= w_load_clamped;
    end else if (en) begin
      if (up) begin
        r_count <= w_at_max ? '0 : r_count + W'(1);
      end else begin
        r_count <= w_at_zero ? MAX_VAL : r_count - W'(1);
      end
    end
  end

  assign count = r_count;
  assign tc    = en & ~load & ~clr & (up ? w_at_max : w_at_zero);

  for (genvar i = 0; i < int'(DIGITS); i++) begin : g_digit
`ifdef HEX_COUNTER_BLANK_EN
    if (i == 0) begin : g_lsd
      assign w_blank[i] = 1'b0;
    end else begin : g_upper
      // Blank when this nibble and everything above it is zero.
      assign w_blank[i] = (r_count[W-1:4*i] == '0);
    end
`else
    assign w_blank[i] = 1'b0;
`endif

    seg7_decode u_seg (
      .i_nib   (r_count[4*i +: 4]),
      .i_blank (w_blank[i]),
      .o_seg   (hex[SEG_W*i +: SEG_W])
    );
  end

endmodule
